gps_multi_sv_capture: RTL and testbench

//  Single-clock, parametrised successor to the GPS code front end. Sequences one round over NUM_SV

---
 rtl/gps_pkg.sv | 9 +
 rtl/gps_shift_capture.sv | 40 ++++
 rtl/gps_multi_sv_capture.sv | 113 +++++++++++
 tb/tb_gps_multi_sv_capture.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gps_pkg.sv
// Shared types and constants for the GPS multi-SV capture front end and the AES stage behind it.
package gps_pkg;
  localparam int SV_W = 6;

  typedef enum logic [1:0] {IDLE, LOAD, CAPTURE, PRESENT} state_e;

  // Key used by the downstream AES stage
  localparam logic [127:0] AES_KEY = 128'h2b7e_1516_28ae_d2a6_abf7_1588_09cf_4f3c;
endpackage

// File: rtl/gps_shift_capture.sv
// Serial-in shift register, first bit ends at MSB; saturating count stops shifting once LEN bits are in.
module gps_shift_capture #(
  parameter int LEN = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic           din,
  output logic           full_o,
  output logic [LEN-1:0] data_o
);
  localparam int CW = $clog2(LEN + 1);

  logic [CW-1:0]  cnt;
  logic [LEN-1:0] nxt;

  assign full_o = (cnt == CW'(LEN));

  generate
    if (LEN == 1) begin : g_one
      assign nxt = din;
    end else begin : g_multi
      assign nxt = {data_o[LEN-2:0], din};
    end
  endgenerate

  // clr resets only the count; the data keeps its last block until overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      data_o <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !full_o) begin
      cnt    <= cnt + 1'b1;
      data_o <= nxt;
    end
  end
endmodule

// File: rtl/gps_multi_sv_capture.sv
// Round sequencer: per SV reload generators, capture C/A and P chips, present block on valid/ready.
// Optional GPS_CAPTURE_STATS_EN adds stall_cnt_out (cycles presented but not accepted).
module gps_multi_sv_capture
  import gps_pkg::*;
#(
  parameter int NUM_SV = 4,
  parameter int CA_LEN = 13,
  parameter int P_LEN  = 128
) (
  input  logic                     gps_clk,
  input  logic                     async_rst_n_in,
  input  logic                     start_round_in,
  input  logic [NUM_SV*SV_W-1:0]   sv_list_in,
  output logic [SV_W-1:0]          gen_sv_out,
  output logic                     gen_load_out,
  output logic                     gen_en_out,
  input  logic                     ca_tick_in,
  input  logic                     ca_bit_in,
  input  logic                     p_bit_in,
  output logic [CA_LEN-1:0]        ca_code_out,
  output logic [P_LEN-1:0]         p_block_out,
  output logic [SV_W-1:0]          blk_sv_out,
  output logic                     blk_valid_out,
  input  logic                     blk_ready_in,
  output logic                     busy_out,
  output logic                     round_done_out
`ifdef GPS_CAPTURE_STATS_EN
  ,output logic [15:0]             stall_cnt_out
`endif
);
  localparam int IW = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;

  state_e                   state, state_nxt;
  logic                     start_q;
  logic [NUM_SV*SV_W-1:0]   sv_lat;
  logic [IW-1:0]            idx;
  logic                     start_edge, handshake, last_sv;
  logic                     ca_full, p_full;

  assign start_edge = start_round_in & ~start_q;
  assign handshake  = (state == PRESENT) & blk_ready_in;
  assign last_sv    = (idx == IW'(NUM_SV - 1));

  assign gen_sv_out    = sv_lat[idx*SV_W +: SV_W];
  assign blk_sv_out    = gen_sv_out;
  assign gen_load_out  = (state == LOAD);
  assign gen_en_out    = (state == CAPTURE);
  assign blk_valid_out = (state == PRESENT);
  assign busy_out      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = LOAD;
      LOAD:    state_nxt = CAPTURE;
      CAPTURE: if (ca_full && p_full) state_nxt = PRESENT;
      PRESENT: if (handshake) state_nxt = last_sv ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gps_clk or negedge async_rst_n_in) begin
    if (!async_rst_n_in) begin
      state          <= IDLE;
      start_q        <= 1'b0;
      sv_lat         <= '0;
      idx            <= '0;
      round_done_out <= 1'b0;
    end else begin
      state          <= state_nxt;
      start_q        <= start_round_in;
      round_done_out <= handshake & last_sv;
      if (state == IDLE && start_edge) begin
        sv_lat <= sv_list_in;
        idx    <= '0;
      end else if (handshake && !last_sv) begin
        idx <= idx + 1'b1;
      end
    end
  end

  gps_shift_capture #(.LEN(CA_LEN)) u_ca_cap (
    .clk    (gps_clk),
    .rst_n  (async_rst_n_in),
    .clr    (gen_load_out),
    .en     (gen_en_out & ca_tick_in),
    .din    (ca_bit_in),
    .full_o (ca_full),
    .data_o (ca_code_out)
  );

  // P chips are valid on every enabled cycle, so no tick qualifier
  gps_shift_capture #(.LEN(P_LEN)) u_p_cap (
    .clk    (gps_clk),
    .rst_n  (async_rst_n_in),
    .clr    (gen_load_out),
    .en     (gen_en_out),
    .din    (p_bit_in),
    .full_o (p_full),
    .data_o (p_block_out)
  );

`ifdef GPS_CAPTURE_STATS_EN
  always_ff @(posedge gps_clk or negedge async_rst_n_in) begin
    if (!async_rst_n_in)
      stall_cnt_out <= '0;
    else if (state == IDLE && start_edge)
      stall_cnt_out <= '0;
    else if (blk_valid_out && !blk_ready_in && stall_cnt_out != 16'hFFFF)
      stall_cnt_out <= stall_cnt_out + 16'd1;
  end
`endif
endmodule

// File: tb/tb_gps_multi_sv_capture.sv
// Directed bench for gps_multi_sv_capture (NUM_SV=4, CA_LEN=13, P_LEN=128).
module tb_gps_multi_sv_capture;
  localparam logic [127:0] PA  = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] PB  = 128'h1;
  localparam logic [12:0]  CAA = 13'h1000;
  localparam logic [12:0]  CAB = 13'h0001;

  logic         gps_clk = 1'b0;
  logic         async_rst_n_in = 1'b0;
  logic         start_round_in = 1'b0;
  logic [23:0]  sv_list_in = '0;
  logic [5:0]   gen_sv_out;
  logic         gen_load_out, gen_en_out;
  logic         ca_tick_in = 1'b0, ca_bit_in = 1'b0, p_bit_in = 1'b0;
  logic [12:0]  ca_code_out;
  logic [127:0] p_block_out;
  logic [5:0]   blk_sv_out;
  logic         blk_valid_out;
  logic         blk_ready_in = 1'b0;
  logic         busy_out, round_done_out;
`ifdef GPS_CAPTURE_STATS_EN
  logic [15:0]  stall_cnt_out;
`endif

  gps_multi_sv_capture #(.NUM_SV(4), .CA_LEN(13), .P_LEN(128)) dut (
    .gps_clk        (gps_clk),
    .async_rst_n_in (async_rst_n_in),
    .start_round_in (start_round_in),
    .sv_list_in     (sv_list_in),
    .gen_sv_out     (gen_sv_out),
    .gen_load_out   (gen_load_out),
    .gen_en_out     (gen_en_out),
    .ca_tick_in     (ca_tick_in),
    .ca_bit_in      (ca_bit_in),
    .p_bit_in       (p_bit_in),
    .ca_code_out    (ca_code_out),
    .p_block_out    (p_block_out),
    .blk_sv_out     (blk_sv_out),
    .blk_valid_out  (blk_valid_out),
    .blk_ready_in   (blk_ready_in),
    .busy_out       (busy_out),
    .round_done_out (round_done_out)
`ifdef GPS_CAPTURE_STATS_EN
    ,.stall_cnt_out (stall_cnt_out)
`endif
  );

  always #5 gps_clk = ~gps_clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, load_cyc = 0, vld_cyc = 0;
  int n_load = 0, n_done = 0;
  int cap_cyc = 0, tick_no = 0, tick_period = 1;
  bit pmode = 1'b0;

  always @(posedge gps_clk) cyc <= cyc + 1;

  always @(negedge gps_clk) begin
    if (gen_load_out)   n_load <= n_load + 1;
    if (round_done_out) n_done <= n_done + 1;
  end

  // Chip source: pattern A = single 1 on first chip, pattern B = 1 from the last valid chip onward
  always @(posedge gps_clk) begin
    #1;
    if (gen_en_out) cap_cyc = cap_cyc + 1;
    else begin cap_cyc = 0; tick_no = 0; end
    ca_tick_in = gen_en_out && (cap_cyc % tick_period == 0);
    if (ca_tick_in) tick_no = tick_no + 1;
    ca_bit_in = pmode ? (tick_no >= 13) : (tick_no == 1);
    p_bit_in  = pmode ? (cap_cyc >= 128) : (cap_cyc == 1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gen_sv"}, gen_sv_out, 0);
    chk({tag, ".gen_load"}, gen_load_out, 0);
    chk({tag, ".gen_en"}, gen_en_out, 0);
    chk({tag, ".ca_code"}, ca_code_out, 0);
    chk({tag, ".p_block"}, p_block_out, 0);
    chk({tag, ".blk_sv"}, blk_sv_out, 0);
    chk({tag, ".blk_valid"}, blk_valid_out, 0);
    chk({tag, ".busy"}, busy_out, 0);
    chk({tag, ".round_done"}, round_done_out, 0);
`ifdef GPS_CAPTURE_STATS_EN
    chk({tag, ".stall_cnt"}, stall_cnt_out, 0);
`endif
  endtask

  task automatic start(input logic [23:0] list);
    sv_list_in     = list;
    start_round_in = 1'b1;
    @(posedge gps_clk); #1;
    start_round_in = 1'b0;
  endtask

  task automatic wait_load(input logic [5:0] sv);
    int t = 0;
    while (!gen_load_out && t < 50) begin @(posedge gps_clk); #1; t++; end
    chk("gen_load", gen_load_out, 1);
    chk("gen_sv", gen_sv_out, sv);
    load_cyc = cyc;
  endtask

  task automatic wait_blk(input logic [5:0] sv, input logic [127:0] ep, input logic [12:0] eca,
                          input int stall);
    int t = 0;
    while (!blk_valid_out && t < 400) begin @(posedge gps_clk); #1; t++; end
    vld_cyc = cyc;
    for (int k = 0; k <= stall; k++) begin
      if (k == stall) blk_ready_in = 1'b1;
      chk("blk_valid", blk_valid_out, 1);
      chk("gen_en_in_present", gen_en_out, 0);
      chk("blk_sv", blk_sv_out, sv);
      chk("p_block", p_block_out, ep);
      chk("ca_code", ca_code_out, eca);
      @(posedge gps_clk); #1;
    end
    blk_ready_in = 1'b0;
  endtask

  task automatic run_round(input logic [23:0] list, input int period, input bit mode,
                           input int stall, input logic [127:0] ep, input logic [12:0] eca,
                           input int lat);
    int l0, d0;
    logic [23:0] lv;
    lv = list;
    tick_period = period;
    pmode = mode;
    l0 = n_load; d0 = n_done;
    start(list);
    for (int i = 0; i < 4; i++) begin
      wait_load(lv[6*i +: 6]);
      chk("busy_in_round", busy_out, 1);
      wait_blk(lv[6*i +: 6], ep, eca, stall);
      if (i == 0) chk("valid_latency", vld_cyc - load_cyc, lat);
    end
    chk("round_done_pulse", round_done_out, 1);
    chk("busy_after_round", busy_out, 0);
    @(posedge gps_clk); #1;
    chk("round_done_width", round_done_out, 0);
    chk("load_pulses", n_load - l0, 4);
    chk("done_pulses", n_done - d0, 1);
  endtask

  initial begin
    int d0;
    // 1: reset, then idle with no start edge
    repeat (3) @(posedge gps_clk);
    #1 chk_zero("in_reset");
    async_rst_n_in = 1'b1;
    repeat (5) begin @(posedge gps_clk); #1; chk_zero("idle"); end

    // 2: slow ticks every 10 cycles, first SV 5, valid after 13th tick
    run_round({6'd4, 6'd3, 6'd2, 6'd5}, 10, 1'b0, 0, PA, CAA, 132);

    // 3: tick every cycle, single-1 pattern
    run_round({6'd40, 6'd33, 6'd20, 6'd9}, 1, 1'b0, 0, PA, CAA, 130);

    // 4: stalled blocks, last-chip pattern exercises saturation; 6: next round one cycle after done
    run_round({6'd31, 6'd12, 6'd7, 6'd1}, 1, 1'b1, 20, PB, CAB, 130);
`ifdef GPS_CAPTURE_STATS_EN
    chk("stall_cnt", stall_cnt_out, 80);
`endif
    run_round({6'd63, 6'd0, 6'd17, 6'd2}, 1, 1'b0, 0, PA, CAA, 130);

    // 5: start edge mid-CAPTURE ignored, then async reset mid-CAPTURE
    tick_period = 1; pmode = 1'b0;
    start({6'd6, 6'd5, 6'd4, 6'd3});
    wait_load(6'd3);
    repeat (30) @(posedge gps_clk);
    #1 start_round_in = 1'b1;
    @(posedge gps_clk); #1;
    start_round_in = 1'b0;
    chk("ignored_start.load", gen_load_out, 0);
    chk("ignored_start.gen_en", gen_en_out, 1);
    chk("ignored_start.busy", busy_out, 1);
    repeat (5) @(posedge gps_clk);
    d0 = n_done;
    #2 async_rst_n_in = 1'b0;
    #1 chk_zero("abort");
    @(posedge gps_clk); #1;
    chk_zero("abort_hold");
    async_rst_n_in = 1'b1;
    @(posedge gps_clk); #1;
    chk("abort_no_done", n_done - d0, 0);
    run_round({6'd44, 6'd21, 6'd11, 6'd8}, 1, 1'b1, 0, PB, CAB, 130);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
